// File: rtl/fpu_ret_collect_pkg.sv
// Shared constants for FP completion records: record width, IEEE flag field and lane ids.
package fpu_ret_collect_pkg;

  localparam int unsigned RET_W    = 14;
  localparam int unsigned FLAG_LSB = 0;
  localparam int unsigned FLAG_W   = 5;
  localparam int unsigned LANES    = 3;
  localparam int unsigned OUT_W    = RET_W + 2;

  typedef enum logic [1:0] {
    LANE_U1   = 2'd0,
    LANE_U3   = 2'd1,
    LANE_U5   = 2'd2,
    LANE_NONE = 2'd3
  } lane_e;

  typedef struct packed {
    lane_e            lane;
    logic [RET_W-1:0] ret;
  } ret_rec_t;

endpackage

// File: rtl/fpu_ret_collect_if.sv
// Completion-record bus between the FP lanes/retire stage and the return collector.
interface fpu_ret_collect_if;
  import fpu_ret_collect_pkg::*;

  logic [RET_W-1:0]  u1_ret;
  logic              u1_ret_en;
  logic [RET_W-1:0]  u3_ret;
  logic              u3_ret_en;
  logic [RET_W-1:0]  u5_ret;
  logic              u5_ret_en;
  logic [OUT_W-1:0]  ret_out;
  logic              ret_valid;
  logic              ret_ready;
  logic              flags_clr;
  logic [FLAG_W-1:0] fp_flags;
  logic              fpu_stall;
  logic              ovf_err;

  modport master (
    output u1_ret, u1_ret_en, u3_ret, u3_ret_en, u5_ret, u5_ret_en,
    output ret_ready, flags_clr,
    input  ret_out, ret_valid, fp_flags, fpu_stall, ovf_err
  );

  modport slave (
    input  u1_ret, u1_ret_en, u3_ret, u3_ret_en, u5_ret, u5_ret_en,
    input  ret_ready, flags_clr,
    output ret_out, ret_valid, fp_flags, fpu_stall, ovf_err
  );

endinterface

// File: rtl/fpu_ret_compact.sv
// Compacts the three lane enables into in-order push slots and a push count (0..3).
module fpu_ret_compact
  import fpu_ret_collect_pkg::*;
(
  input  logic [LANES-1:0] en_i,
  output lane_e            slot_lane_o [LANES],
  output logic [1:0]       push_cnt_o
);

  logic [1:0] idx;

  always_comb begin
    idx = '0;
    for (int unsigned s = 0; s < LANES; s++) slot_lane_o[s] = LANE_NONE;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (en_i[l]) begin
        slot_lane_o[idx] = lane_e'(l[1:0]);
        idx = idx + 2'd1;
      end
    end
    push_cnt_o = idx;
  end

endmodule

// File: rtl/fpu_ret_collect.sv
// Collects up to three lane completions per cycle into a circular buffer, drains one per
// cycle to retire, accumulates sticky IEEE flags and backpressures the scheduler.
module fpu_ret_collect
  import fpu_ret_collect_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input logic               clk,
  input logic               rst,
  fpu_ret_collect_if.slave  bus
);

  ret_rec_t          mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              stall_q, ovf_q, ovf_d;

  lane_e             slot_lane [LANES];
  ret_rec_t          slot_rec  [LANES];
  logic [1:0]        push_cnt, n_acc;
  logic [AW:0]       kept, room;
  logic              fire;
  ret_rec_t          head;

  fpu_ret_compact u_compact (
    .en_i        ({bus.u5_ret_en, bus.u3_ret_en, bus.u1_ret_en}),
    .slot_lane_o (slot_lane),
    .push_cnt_o  (push_cnt)
  );

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      slot_rec[k].lane = slot_lane[k];
      case (slot_lane[k])
        LANE_U1: slot_rec[k].ret = bus.u1_ret;
        LANE_U3: slot_rec[k].ret = bus.u3_ret;
        LANE_U5: slot_rec[k].ret = bus.u5_ret;
        default: slot_rec[k].ret = '0;
      endcase
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.ret_valid = (count_q != '0);
  assign bus.ret_out   = bus.ret_valid ? head : '0;
  assign bus.fp_flags  = flags_q;
  assign bus.fpu_stall = stall_q;
  assign bus.ovf_err   = ovf_q;

  // Room is measured after this cycle's pop, so a drain frees a slot for a same-cycle push;
  // the slots beyond the room are the latest lanes and are the ones dropped.
  always_comb begin
    fire     = bus.ret_valid & bus.ret_ready;
    kept     = count_q - (AW+1)'(fire);
    room     = (AW+1)'(DEPTH) - kept;
    n_acc    = (room < (AW+1)'(push_cnt)) ? room[1:0] : push_cnt;
    ovf_d    = ovf_q | (push_cnt != n_acc);
    count_d  = kept + (AW+1)'(n_acc);
    wr_ptr_d = wr_ptr_q + AW'(n_acc);
    rd_ptr_d = rd_ptr_q + AW'(fire);
    flags_d  = (bus.flags_clr ? '0 : flags_q)
             | (fire ? head.ret[FLAG_LSB +: FLAG_W] : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
      stall_q  <= (count_d > (AW+1)'(DEPTH - 3));
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (k < 32'(n_acc)) mem_q[wr_ptr_q + AW'(k)] <= slot_rec[k];
      end
    end
  end

endmodule

// File: tb/tb_fpu_ret_collect.sv
// Self-checking bench for fpu_ret_collect against a queue-based reference model.
module tb_fpu_ret_collect;
  import fpu_ret_collect_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_ret_collect_if bus();

  fpu_ret_collect #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [15:0] mq [$];
  logic [4:0]  m_flags;
  logic        m_stall;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_flags = '0;
    m_stall = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic drive(input logic [2:0] en, input logic [13:0] r1, input logic [13:0] r3,
                       input logic [13:0] r5, input logic rdy, input logic clr);
    bus.u1_ret_en = en[0];
    bus.u3_ret_en = en[1];
    bus.u5_ret_en = en[2];
    bus.u1_ret    = r1;
    bus.u3_ret    = r3;
    bus.u5_ret    = r5;
    bus.ret_ready = rdy;
    bus.flags_clr = clr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(3'b111, 14'($urandom), 14'($urandom), 14'($urandom), 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: apply inputs, check outputs against the model, then advance the model.
  task automatic cycle(input logic [2:0] en, input logic [13:0] r1, input logic [13:0] r3,
                       input logic [13:0] r5, input logic rdy, input logic clr);
    logic [15:0] head;
    logic [13:0] rr [3];
    drive(en, r1, r3, r5, rdy, clr);
    #1;
    head = (mq.size() != 0) ? mq[0] : 16'h0;
    chk("ret_valid", 32'(bus.ret_valid), 32'(mq.size() != 0));
    chk("ret_out",   32'(bus.ret_out),   32'(head));
    chk("fp_flags",  32'(bus.fp_flags),  32'(m_flags));
    chk("fpu_stall", 32'(bus.fpu_stall), 32'(m_stall));
    chk("ovf_err",   32'(bus.ovf_err),   32'(m_ovf));
    if (mq.size() != 0 && rdy) begin
      void'(mq.pop_front());
      m_flags = (clr ? 5'h0 : m_flags) | head[4:0];
    end else if (clr) begin
      m_flags = 5'h0;
    end
    rr = '{r1, r3, r5};
    for (int l = 0; l < 3; l++) begin
      if (en[l]) begin
        if (mq.size() < DEPTH) mq.push_back({2'(l), rr[l]});
        else m_ovf = 1'b1;
      end
    end
    m_stall = (mq.size() > DEPTH - 3);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(3'b000, 14'h0, 14'h0, 14'h0, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    drive(3'b000, '0, '0, '0, 1'b0, 1'b0);

    // Reset with all lanes enabled: nothing queued afterwards
    do_reset();
    chk("rst_valid", 32'(bus.ret_valid), 32'd0);
    chk("rst_flags", 32'(bus.fp_flags), 32'd0);
    idle(1'b0);
    idle(1'b1);

    // Lane ordering u1,u3,u5
    do_reset();
    cycle(3'b111, 14'h001, 14'h002, 14'h004, 1'b1, 1'b0);
    chk("order0", 32'(bus.ret_out), 32'h0001);
    idle(1'b1);
    chk("order1", 32'(bus.ret_out), 32'h4002);
    idle(1'b1);
    chk("order2", 32'(bus.ret_out), 32'h8004);
    idle(1'b1);
    idle(1'b1);
    chk("order_flags", 32'(bus.fp_flags), 32'h07);

    // Fill to full with no drain; third cycle drops u5
    do_reset();
    repeat (3) cycle(3'b111, 14'($urandom), 14'($urandom), 14'($urandom), 1'b0, 1'b0);
    chk("full_stall", 32'(bus.fpu_stall), 32'd1);
    chk("full_ovf", 32'(bus.ovf_err), 32'd1);
    idle(1'b0);
    repeat (10) idle(1'b1);

    // Simultaneous pop and push while full
    do_reset();
    cycle(3'b111, 14'($urandom), 14'($urandom), 14'($urandom), 1'b0, 1'b0);
    cycle(3'b111, 14'($urandom), 14'($urandom), 14'($urandom), 1'b0, 1'b0);
    cycle(3'b011, 14'($urandom), 14'($urandom), 14'($urandom), 1'b0, 1'b0);
    cycle(3'b001, 14'($urandom), 14'($urandom), 14'($urandom), 1'b1, 1'b0);
    chk("simul_ovf", 32'(bus.ovf_err), 32'd0);
    chk("simul_stall", 32'(bus.fpu_stall), 32'd1);
    idle(1'b0);
    repeat (10) idle(1'b1);

    // Pointer wrap with single-lane records and 50% drain
    do_reset();
    for (int i = 0; i < 20; i++)
      cycle(3'(1 << $urandom_range(2, 0)), 14'($urandom), 14'($urandom), 14'($urandom),
            1'($urandom % 2), 1'b0);
    repeat (24) idle(1'b1);
    chk("wrap_drained", 32'(bus.ret_valid), 32'd0);

    // Flag clear racing a drain
    do_reset();
    cycle(3'b001, 14'h010, 14'h0, 14'h0, 1'b1, 1'b0);
    idle(1'b1);
    cycle(3'b001, 14'h001, 14'h0, 14'h0, 1'b0, 1'b0);
    chk("race_pre", 32'(bus.fp_flags), 32'h10);
    cycle(3'b000, 14'h0, 14'h0, 14'h0, 1'b1, 1'b1);
    chk("clr_race", 32'(bus.fp_flags), 32'h01);
    idle(1'b0);

    // Random traffic with a reset in the middle
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cycle(3'($urandom), 14'($urandom), 14'($urandom), 14'($urandom),
            1'($urandom_range(3, 0) != 0), 1'($urandom_range(15, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
